// File: rtl/op_16bit_pkg.sv
// Shared constants for the half-word shift/rotate block: default data width
// and the encoding of the direction select.
package op_16bit_pkg;

    // Default operand width; must be even because the operand is split in halves.
    localparam int WIDTH_DEFAULT = 32;

    // Direction select encoding.
    localparam logic OP_LEFT  = 1'b0;
    localparam logic OP_RIGHT = 1'b1;

endpackage : op_16bit_pkg

// File: rtl/op_16bit_half_shifter.sv
// Combinational half-word shifter/rotator. It moves the operand by exactly
// WIDTH/2 bit positions. A rotate by half the width gives the same result in
// either direction, so rotate ignores both op and sra.
module half_shifter
    import op_16bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             sra,
    input  logic             rotate,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    localparam int H = WIDTH / 2;

    logic [H-1:0] lo;
    logic [H-1:0] hi;
    logic [H-1:0] right_fill;

    assign lo = a[H-1:0];
    assign hi = a[WIDTH-1:H];

    // Fill for right shifts: copies of the sign bit when sra is set, zeros otherwise.
    assign right_fill = sra ? {H{a[WIDTH-1]}} : {H{1'b0}};

    // Select the result: rotate wins, otherwise shift left or right by H.
    always_comb begin
        y = {lo, {H{1'b0}}};
        if (rotate) begin
            y = {lo, hi};
        end else begin
            case (op)
                OP_LEFT:  y = {lo, {H{1'b0}}};
                OP_RIGHT: y = {right_fill, hi};
                default:  y = {lo, {H{1'b0}}};
            endcase
        end
    end

endmodule : half_shifter

// File: rtl/op_16bit.sv
// Registered half-word shift/rotate. The block accepts one operation per cycle
// and applies no backpressure. Its result appears exactly one cycle after the
// accepting edge. Idle cycles keep the last result and zero flag unchanged.
module op_16bit
    import op_16bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sra,
    input  logic             rotate,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out4,
    output logic             out_valid,
    output logic             zero
);

    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] out4_d;
    logic [WIDTH-1:0] out4_q;
    logic             out_valid_d;
    logic             out_valid_q;
    logic             zero_d;
    logic             zero_q;

    half_shifter #(
        .WIDTH (WIDTH)
    ) u_half_shifter (
        .sra    (sra),
        .rotate (rotate),
        .op     (op),
        .a      (a),
        .y      (shift_y)
    );

    // Next state: load a new result on in_valid, otherwise hold result and flag.
    always_comb begin
        out4_d      = out4_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out4_d = shift_y;
            zero_d = (shift_y == '0);
        end
    end

    // Output registers. Reset clears the result and asserts zero to match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out4_q      <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            out4_q      <= out4_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
        end
    end

    assign out4      = out4_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;

endmodule : op_16bit

// File: tb/tb_op_16bit.sv
// Scoreboard bench for op_16bit. The stimulus process pushes hand-computed
// expectations into a queue. The monitor pops one entry on every out_valid and
// compares it with the DUT output.
module tb_op_16bit;

    typedef struct {
        logic        op;
        logic        rotate;
        logic        sra;
        logic [31:0] a;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sra;
    logic        rotate;
    logic        op;
    logic [31:0] a;
    logic [31:0] out4;
    logic        out_valid;
    logic        zero;

    int   checks;
    int   errors;
    vec_t sb[$];

    op_16bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sra       (sra),
        .rotate    (rotate),
        .op        (op),
        .a         (a),
        .out4      (out4),
        .out_valid (out_valid),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 with empty scoreboard, out4=%h", out4);
            end else begin
                vec_t e;
                e = sb.pop_front();
                checks++;
                if (out4 !== e.exp_out) begin
                    errors++;
                    $display("FAIL result a=%h op=%b rot=%b sra=%b: got %h expected %h",
                             e.a, e.op, e.rotate, e.sra, out4, e.exp_out);
                end
                checks++;
                if (zero !== e.exp_zero) begin
                    errors++;
                    $display("FAIL zero_flag a=%h: got %b expected %b", e.a, zero, e.exp_zero);
                end
                $display("txn a=%h op=%b rot=%b sra=%b -> out4=%h zero=%b (expected %h/%b)",
                         e.a, e.op, e.rotate, e.sra, out4, zero, e.exp_out, e.exp_zero);
            end
        end
    end

    task automatic check_bits(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present one operation for one cycle and record its expected response.
    task automatic issue(input vec_t v);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = v.op;
        rotate   = v.rotate;
        sra      = v.sra;
        a        = v.a;
        sb.push_back(v);
    endtask

    // Drop in_valid, then check for n idle cycles that the result is held.
    task automatic hold_check(input int n, input logic [31:0] exp_out, input logic exp_zero);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_DEAD;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_bits("idle_out_valid", {31'd0, out_valid}, 32'd0);
            check_bits("idle_out4_held", out4, exp_out);
            check_bits("idle_zero_held", {31'd0, zero}, {31'd0, exp_zero});
        end
    endtask

    vec_t vecs[11];
    vec_t strm[4];
    vec_t post[2];

    initial begin
        //          op    rot   sra   a              expected       zero
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h5678_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h9876_5432, 32'hFFFF_9876, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h8765_4321, 32'hFFFF_8765, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0123_4567, 32'h0000_0123, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h8765_4321, 32'h4321_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hC0FF_EE01, 32'hEE01_C0FF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'hFEDC_BA98, 32'hBA98_FEDC, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_1234, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0001, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'hABCD_0000, 32'h0000_0000, 1'b1};

        strm[0]  = '{1'b0, 1'b1, 1'b0, 32'h1111_2222, 32'h2222_1111, 1'b0};
        strm[1]  = '{1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_8000, 1'b0};
        strm[2]  = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_8000, 1'b0};
        strm[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};

        post[0]  = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b0};
        post[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0001_0000, 1'b0};

        checks   = 0;
        errors   = 0;
        in_valid = 1'b0;
        op       = 1'b0;
        rotate   = 1'b0;
        sra      = 1'b0;
        a        = '0;
        rst_n    = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check_bits("reset_out4", out4, 32'd0);
        check_bits("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_bits("reset_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 10; i++) issue(vecs[i]);
        hold_check(1, 32'h0000_FFFF, 1'b0);

        // All-zero result, then two idle cycles holding it.
        issue(vecs[10]);
        hold_check(2, 32'h0000_0000, 1'b1);

        // Back-to-back stream with reset asserted while the last op is in flight.
        for (int i = 0; i < 4; i++) issue(strm[i]);
        @(negedge clk);
        check_bits("stream_no_bubble", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_bits("midreset_out4", out4, 32'd0);
        check_bits("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check_bits("midreset_zero", {31'd0, zero}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        check_bits("inreset_edge_out_valid", {31'd0, out_valid}, 32'd0);
        check_bits("inreset_edge_out4", out4, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation resumes after release.
        issue(post[0]);
        issue(post[1]);
        hold_check(1, 32'h0001_0000, 1'b0);

        // Every expected response must have been consumed by the monitor.
        check_bits("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_op_16bit
